vga_timing_gen: RTL



---
 rtl/vga_timing_pkg.sv | 27 ++
 rtl/vga_delay_line.sv | 27 ++
 rtl/vga_timing_gen.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing constants for the VGA timing generator: default 640x480@60 timing,
// sync polarity and Pmod channel width.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int CNT_W = 10;
    localparam int CH_W  = 2;

    localparam logic SYNC_ASSERT = 1'b0;
    localparam logic SYNC_IDLE   = 1'b1;

    function automatic logic [CH_W-1:0] ch_fill(input logic b);
        return {CH_W{b}};
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with synchronous active-low clear to a configurable value;
// aligns sync/blank (and bar index) with the renderer's colour latency.
module vga_delay_line #(
    parameter int              WIDTH   = 3,
    parameter int              DEPTH   = 3,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_clr_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge i_clk) begin
        if (!i_clr_n) begin
            for (int i = 0; i < DEPTH; i++) r_stage[i] <= CLR_VAL;
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA pixel counters, sync/blank generation delayed by PIPE_LAT, and RGB output stage.
// Optional colour-bar test pattern: define VGA_TEST_PATTERN_EN.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int PIPE_LAT = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             colour,
`ifdef VGA_TEST_PATTERN_EN
    input  logic             test_mode,
`endif
    output logic [CNT_W-1:0] counter_H,
    output logic [CNT_W-1:0] counter_V,
    output logic             frame_tick,
    output logic             hsync,
    output logic             vsync,
    output logic [CH_W-1:0]  red,
    output logic [CH_W-1:0]  green,
    output logic [CH_W-1:0]  blue
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

`ifdef VGA_TEST_PATTERN_EN
    localparam int              DL_W   = 6;
    localparam logic [DL_W-1:0] DL_CLR = {SYNC_IDLE, SYNC_IDLE, 1'b0, 3'b000};
`else
    localparam int              DL_W   = 3;
    localparam logic [DL_W-1:0] DL_CLR = {SYNC_IDLE, SYNC_IDLE, 1'b0};
`endif

    logic [CNT_W-1:0] r_h_p0, r_v_p0;
    logic             r_frame_tick;
    logic [CNT_W-1:0] w_h_next, w_v_next;
    logic             w_h_wrap;

    assign w_h_wrap = (r_h_p0 == H_LAST);
    assign w_h_next = w_h_wrap ? '0 : r_h_p0 + CNT_W'(1);
    assign w_v_next = !w_h_wrap         ? r_v_p0 :
                      (r_v_p0 == V_LAST) ? '0     : r_v_p0 + CNT_W'(1);

    // stage p0: counters; frame_tick is decoded from the next count so it coincides with (0, V_ACTIVE)
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_h_p0       <= '0;
            r_v_p0       <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            r_h_p0       <= w_h_next;
            r_v_p0       <= w_v_next;
            r_frame_tick <= (w_h_next == '0) && (w_v_next == V_ACT);
        end
    end

    logic w_de_p0, w_hs_n_p0, w_vs_n_p0;

    assign w_de_p0   = (r_h_p0 < H_ACT) && (r_v_p0 < V_ACT);
    assign w_hs_n_p0 = (r_h_p0 >= HS_FIRST && r_h_p0 <= HS_LAST) ? SYNC_ASSERT : SYNC_IDLE;
    assign w_vs_n_p0 = (r_v_p0 >= VS_FIRST && r_v_p0 <= VS_LAST) ? SYNC_ASSERT : SYNC_IDLE;

    logic [DL_W-1:0] w_dl_in, w_dl_out;
    logic            w_de_pd, w_hs_n_pd, w_vs_n_pd;

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] w_bar_pd;
    assign w_dl_in = {w_hs_n_p0, w_vs_n_p0, w_de_p0, r_h_p0[9:7]};
    assign {w_hs_n_pd, w_vs_n_pd, w_de_pd, w_bar_pd} = w_dl_out;
`else
    assign w_dl_in = {w_hs_n_p0, w_vs_n_p0, w_de_p0};
    assign {w_hs_n_pd, w_vs_n_pd, w_de_pd} = w_dl_out;
`endif

    vga_delay_line #(
        .WIDTH   (DL_W),
        .DEPTH   (PIPE_LAT),
        .CLR_VAL (DL_CLR)
    ) u_delay (
        .i_clk   (clk),
        .i_clr_n (reset),
        .i_d     (w_dl_in),
        .o_q     (w_dl_out)
    );

    logic [CH_W-1:0] w_red, w_green, w_blue;

    always_comb begin
        w_red   = '0;
        w_green = '0;
        w_blue  = '0;
        if (w_de_pd) begin
`ifdef VGA_TEST_PATTERN_EN
            if (test_mode) begin
                w_red   = ch_fill(w_bar_pd[2]);
                w_green = ch_fill(w_bar_pd[1]);
                w_blue  = ch_fill(w_bar_pd[0]);
            end else
`endif
            begin
                w_red   = ch_fill(colour);
                w_green = ch_fill(colour);
                w_blue  = ch_fill(colour);
            end
        end
    end

    logic            r_hsync_p1, r_vsync_p1;
    logic [CH_W-1:0] r_red_p1, r_green_p1, r_blue_p1;

    // stage p1: output register, one cycle after colour is sampled
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hsync_p1 <= SYNC_IDLE;
            r_vsync_p1 <= SYNC_IDLE;
            r_red_p1   <= '0;
            r_green_p1 <= '0;
            r_blue_p1  <= '0;
        end else begin
            r_hsync_p1 <= w_hs_n_pd;
            r_vsync_p1 <= w_vs_n_pd;
            r_red_p1   <= w_red;
            r_green_p1 <= w_green;
            r_blue_p1  <= w_blue;
        end
    end

    assign counter_H  = r_h_p0;
    assign counter_V  = r_v_p0;
    assign frame_tick = r_frame_tick;
    assign hsync      = r_hsync_p1;
    assign vsync      = r_vsync_p1;
    assign red        = r_red_p1;
    assign green      = r_green_p1;
    assign blue       = r_blue_p1;

endmodule
